pkt_capture_ctrl: RTL and testbench

//  Sequencer for the 64-bit sync-detecting shift buffer. Gates its shift enable from the receiver bit strobe.

---
 rtl/pkt_capture_pkg.sv | 20 ++
 rtl/pkt_capture_ctrl_if.sv | 13 +
 rtl/frame_align_pipe.sv | 35 +++
 rtl/pkt_capture_ctrl.sv | 156 +++++++++++++++
 tb/tb_pkt_capture_ctrl.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pkt_capture_pkg.sv
// Shared constants, state encoding and small helpers for the packet capture sequencer.
package pkt_capture_pkg;

    localparam int FRAME_W    = 64;
    localparam int SYNC_LAT   = 2;
    localparam int PKT_CNT_W  = 16;
    localparam int DROP_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HUNT  = 2'd2,
        ST_HOLD  = 2'd3
    } cap_state_t;

    function automatic logic [DROP_CNT_W-1:0] drop_sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (v == '1) ? v : v + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/pkt_capture_ctrl_if.sv
// Downstream frame handoff: valid/ready handshake carrying one captured frame.
interface pkt_capture_ctrl_if
    import pkt_capture_pkg::*;
#(
    parameter int W = FRAME_W
);
    logic [W-1:0] frame_data;
    logic         frame_valid;
    logic         frame_ready;

    modport master (output frame_data, output frame_valid, input  frame_ready);
    modport slave  (input  frame_data, input  frame_valid, output frame_ready);
endinterface

// File: rtl/frame_align_pipe.sv
// Fixed-depth delay line that lines buffer contents and bit count up with the delayed sync flag.
module frame_align_pipe #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [W-1:0] q_reg;
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or posedge rst) begin
                    if (rst)      q_reg <= '0;
                    else if (clr) q_reg <= '0;
                    else          q_reg <= d;
                end
            end else begin : g_tail
                always_ff @(posedge clk or posedge rst) begin
                    if (rst)      q_reg <= '0;
                    else if (clr) q_reg <= '0;
                    else          q_reg <= g_stage[gi-1].q_reg;
                end
            end
        end
    endgenerate

    assign q = g_stage[DEPTH-1].q_reg;

endmodule

// File: rtl/pkt_capture_ctrl.sv
// Capture sequencer for the sync-detecting shift buffer: flush, hunt, hold the frame, hand it off.
module pkt_capture_ctrl #(
    parameter int FRAME_W      = pkt_capture_pkg::FRAME_W,
    parameter int SYNC_LAT     = pkt_capture_pkg::SYNC_LAT,
    parameter int MIN_BITS     = 64,
    parameter int FLUSH_CYCLES = 2,
    parameter int TIMEOUT_CYC  = 4096
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   arm,
    input  logic                                   abort,
    input  logic                                   cont,
    input  logic                                   bit_strobe,
    input  logic                                   sb_pkt_rec,
    input  logic [FRAME_W-1:0]                     sb_dout,
    output logic                                   sb_en,
    output logic                                   sb_rst,
    output logic                                   busy,
    output logic                                   timeout,
    output logic [pkt_capture_pkg::PKT_CNT_W-1:0]  pkt_count,
    output logic [pkt_capture_pkg::DROP_CNT_W-1:0] drop_count,
    pkt_capture_ctrl_if.master                     frm
);
    import pkt_capture_pkg::*;

    localparam int BC_W    = $clog2(MIN_BITS + 1);
    localparam int FL_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int TO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
    localparam bit TO_EN   = (TIMEOUT_CYC > 0);

    cap_state_t             state_reg;
    logic [BC_W-1:0]        bit_cnt_reg;
    logic [FL_W-1:0]        flush_cnt_reg;
    logic [TO_W-1:0]        hunt_cnt_reg;
    logic                   sb_rst_reg;
    logic                   frame_valid_reg;
    logic                   timeout_reg;
    logic [FRAME_W-1:0]     frame_data_reg;
    logic [PKT_CNT_W-1:0]   pkt_count_reg;
    logic [DROP_CNT_W-1:0]  drop_count_reg;

    logic                   pipe_clr;
    logic [FRAME_W+BC_W-1:0] pipe_q;
    logic [FRAME_W-1:0]     dout_dly;
    logic [BC_W-1:0]        bit_cnt_dly;
    logic                   in_hunt;
    logic                   hit;
    logic                   hunt_expire;

    // Buffer contents and strobe count travel together so a hit sees the frame that raised it.
    assign pipe_clr = (state_reg == ST_FLUSH);

    frame_align_pipe #(
        .W     (FRAME_W + BC_W),
        .DEPTH (SYNC_LAT)
    ) u_align (
        .clk (clk),
        .rst (rst),
        .clr (pipe_clr),
        .d   ({sb_dout, bit_cnt_reg}),
        .q   (pipe_q)
    );

    assign dout_dly    = pipe_q[FRAME_W+BC_W-1:BC_W];
    assign bit_cnt_dly = pipe_q[BC_W-1:0];

    assign in_hunt     = (state_reg == ST_HUNT);
    // A flag left over from the previous frame is rejected until a full frame has been shifted in.
    assign hit         = in_hunt && sb_pkt_rec && (bit_cnt_dly >= BC_W'(MIN_BITS));
    assign hunt_expire = in_hunt && TO_EN && (hunt_cnt_reg == TO_W'(TO_LAST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            bit_cnt_reg     <= '0;
            flush_cnt_reg   <= '0;
            hunt_cnt_reg    <= '0;
            sb_rst_reg      <= 1'b0;
            frame_valid_reg <= 1'b0;
            timeout_reg     <= 1'b0;
            frame_data_reg  <= '0;
            pkt_count_reg   <= '0;
            drop_count_reg  <= '0;
        end else begin
            if (bit_strobe && ((state_reg == ST_FLUSH) || (state_reg == ST_HOLD)))
                drop_count_reg <= drop_sat_inc(drop_count_reg);

            if (abort) begin
                state_reg       <= ST_IDLE;
                frame_valid_reg <= 1'b0;
                sb_rst_reg      <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (arm) begin
                            state_reg      <= ST_FLUSH;
                            sb_rst_reg     <= 1'b1;
                            flush_cnt_reg  <= '0;
                            timeout_reg    <= 1'b0;
                            drop_count_reg <= '0;
                        end
                    end
                    ST_FLUSH: begin
                        bit_cnt_reg <= '0;
                        if (flush_cnt_reg == FL_W'(FLUSH_CYCLES - 1)) begin
                            state_reg    <= ST_HUNT;
                            sb_rst_reg   <= 1'b0;
                            hunt_cnt_reg <= '0;
                        end else begin
                            flush_cnt_reg <= flush_cnt_reg + FL_W'(1);
                        end
                    end
                    ST_HUNT: begin
                        hunt_cnt_reg <= hunt_cnt_reg + TO_W'(1);
                        if (bit_strobe && (bit_cnt_reg != BC_W'(MIN_BITS)))
                            bit_cnt_reg <= bit_cnt_reg + BC_W'(1);
                        if (hit) begin
                            frame_data_reg  <= dout_dly;
                            frame_valid_reg <= 1'b1;
                            state_reg       <= ST_HOLD;
                        end else if (hunt_expire) begin
                            state_reg   <= ST_IDLE;
                            timeout_reg <= 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        if (frm.frame_ready) begin
                            frame_valid_reg <= 1'b0;
                            pkt_count_reg   <= pkt_count_reg + PKT_CNT_W'(1);
                            if (cont) begin
                                state_reg     <= ST_FLUSH;
                                sb_rst_reg    <= 1'b1;
                                flush_cnt_reg <= '0;
                            end else begin
                                state_reg <= ST_IDLE;
                            end
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign sb_en           = bit_strobe & in_hunt;
    assign sb_rst          = sb_rst_reg;
    assign busy            = (state_reg != ST_IDLE);
    assign timeout         = timeout_reg;
    assign pkt_count       = pkt_count_reg;
    assign drop_count      = drop_count_reg;
    assign frm.frame_data  = frame_data_reg;
    assign frm.frame_valid = frame_valid_reg;

endmodule

// File: tb/tb_pkt_capture_ctrl.sv
// Bench for pkt_capture_ctrl: behavioural shift buffer plus a frame scoreboard.
module tb_pkt_capture_ctrl;
    import pkt_capture_pkg::*;

    localparam int FW = FRAME_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic arm = 1'b0, arm_to = 1'b0, abort = 1'b0, cont = 1'b0;
    logic bit_strobe = 1'b0, din = 1'b0, force_rec = 1'b0, ready = 1'b0;
    logic sb_en, sb_rst, busy, timeout;
    logic [15:0] pkt_count;
    logic [7:0]  drop_count;
    logic sb_en_to, sb_rst_to, busy_to, timeout_to;
    logic [15:0] pkt_count_to;
    logic [7:0]  drop_count_to;
    logic [FW-1:0] sbuf;
    logic m1, m2, sb_pkt_rec;
    logic [FW-1:0] zero_dout = '0;
    logic zero_rec = 1'b0;

    int errors = 0;
    int checks = 0;
    int exp_pkts = 0;
    logic [FW-1:0] exp_q[$];

    pkt_capture_ctrl_if #(.W(FW)) frm ();
    pkt_capture_ctrl_if #(.W(FW)) frm_to ();
    assign frm.frame_ready    = ready;
    assign frm_to.frame_ready = 1'b1;

    pkt_capture_ctrl dut (
        .clk(clk), .rst(rst), .arm(arm), .abort(abort), .cont(cont),
        .bit_strobe(bit_strobe), .sb_pkt_rec(sb_pkt_rec), .sb_dout(sbuf),
        .sb_en(sb_en), .sb_rst(sb_rst), .busy(busy), .timeout(timeout),
        .pkt_count(pkt_count), .drop_count(drop_count), .frm(frm)
    );

    pkt_capture_ctrl #(.TIMEOUT_CYC(16)) dut_to (
        .clk(clk), .rst(rst), .arm(arm_to), .abort(abort), .cont(cont),
        .bit_strobe(bit_strobe), .sb_pkt_rec(zero_rec), .sb_dout(zero_dout),
        .sb_en(sb_en_to), .sb_rst(sb_rst_to), .busy(busy_to), .timeout(timeout_to),
        .pkt_count(pkt_count_to), .drop_count(drop_count_to), .frm(frm_to)
    );

    // Shift buffer model: sync flag is the top-byte match, seen two cycles late.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sbuf <= '0; m1 <= 1'b0; m2 <= 1'b0;
        end else begin
            if (sb_rst)     sbuf <= '0;
            else if (sb_en) sbuf <= {sbuf[FW-2:0], din};
            m1 <= (sbuf[FW-1:FW-8] == 8'hA5);
            m2 <= m1;
        end
    end
    assign sb_pkt_rec = m2 | force_rec;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mk_word();
        logic [31:0] a;
        logic [23:0] b;
        a = $urandom();
        b = 24'($urandom());
        return {8'hA5, a, b};
    endfunction

    task automatic wait_flush(output int len, output bit ok);
        int g;
        g = 0; len = 0;
        while (!sb_rst && g < 20) begin step(); g++; end
        while (sb_rst && len < 20) begin len++; step(); end
        ok = (g < 20) && (len < 20);
    endtask

    task automatic shift_bits(input logic [63:0] w, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            din = w[i]; bit_strobe = 1'b1;
            step();
        end
        bit_strobe = 1'b0;
    endtask

    task automatic wait_frame(input bit strobe_rand, output int n, output bit ok);
        n = 0;
        while (!frm.frame_valid && n < 30) begin
            if (strobe_rand) begin bit_strobe = 1'b1; din = 1'($urandom()); end
            step(); n++;
        end
        bit_strobe = 1'b0;
        ok = frm.frame_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1; bit_strobe = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || busy_to !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b/%b want 0/0", busy, busy_to); end
        checks++; if (sb_en !== 1'b0 || sb_rst !== 1'b0) begin errors++; $display("FAIL reset_sb: sb_en=%b sb_rst=%b want 0/0", sb_en, sb_rst); end
        checks++; if (frm.frame_valid !== 1'b0 || frm.frame_data !== '0) begin errors++; $display("FAIL reset_frame: valid=%b data=%h want 0", frm.frame_valid, frm.frame_data); end
        checks++; if (pkt_count !== 16'd0 || drop_count !== 8'd0 || timeout !== 1'b0) begin errors++; $display("FAIL reset_counts: pkt=%0d drop=%0d to=%b want 0", pkt_count, drop_count, timeout); end
        bit_strobe = 1'b0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        logic [63:0] w, e;
        int n, len;
        bit ok;
        cont = 1'b0; arm = 1'b1; step(); arm = 1'b0;
        wait_flush(len, ok);
        checks++; if (!ok || len != 2) begin errors++; $display("FAIL t1_flush_len: got %0d want 2", len); end
        w = mk_word(); shift_bits(w, 64); exp_q.push_back(w);
        wait_frame(1'b0, n, ok);
        checks++; if (!ok || n != 3) begin errors++; $display("FAIL t1_hit_latency: got %0d cycles (valid=%b) want 3", n, ok); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        checks++; if (frm.frame_data !== e) begin errors++; $display("FAIL t1_data: got %h want %h", frm.frame_data, e); end
        $display("frame t1 data=%h expected=%h", frm.frame_data, e);
        ready = 1'b1; step(); ready = 1'b0; exp_pkts++;
        checks++; if (frm.frame_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL t1_after_hs: valid=%b busy=%b want 0/0", frm.frame_valid, busy); end
        checks++; if (pkt_count !== 16'(exp_pkts)) begin errors++; $display("FAIL t1_pkt_count: got %0d want %0d", pkt_count, exp_pkts); end
        repeat (4) step();
        checks++; if (frm.frame_valid !== 1'b0) begin errors++; $display("FAIL t1_single_valid: got %b want 0", frm.frame_valid); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] w, e;
        int n, len, drops;
        bit ok, stable;
        cont = 1'b1; arm = 1'b1; step(); arm = 1'b0;
        wait_flush(len, ok);
        checks++; if (!ok || len != 2) begin errors++; $display("FAIL t2_flush1_len: got %0d want 2", len); end
        w = mk_word(); shift_bits(w, 64); exp_q.push_back(w);
        wait_frame(1'b0, n, ok);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        checks++; if (!ok || frm.frame_data !== e) begin errors++; $display("FAIL t2_data1: got %h want %h", frm.frame_data, e); end
        $display("frame t2a data=%h expected=%h", frm.frame_data, e);
        drops = 0; stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bit_strobe = (k % 2 == 0); din = 1'b1;
            if (bit_strobe) drops++;
            #1;
            if (frm.frame_valid !== 1'b1 || frm.frame_data !== e || sb_en !== 1'b0) stable = 1'b0;
            @(posedge clk); #1;
        end
        bit_strobe = 1'b0;
        checks++; if (!stable) begin errors++; $display("FAIL t2_hold_stable: valid=%b data=%h want 1/%h sb_en=0", frm.frame_valid, frm.frame_data, e); end
        ready = 1'b1; step(); ready = 1'b0; exp_pkts++;
        checks++; if (drop_count !== 8'(drops)) begin errors++; $display("FAIL t2_drop_count: got %0d want %0d", drop_count, drops); end
        checks++; if (frm.frame_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL t2_rearm: valid=%b busy=%b want 0/1", frm.frame_valid, busy); end
        wait_flush(len, ok);
        checks++; if (!ok || len != 2) begin errors++; $display("FAIL t2_flush2_len: got %0d want 2", len); end
        w = mk_word(); shift_bits(w, 64); exp_q.push_back(w);
        wait_frame(1'b0, n, ok);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        checks++; if (!ok || frm.frame_data !== e) begin errors++; $display("FAIL t2_data2: got %h want %h", frm.frame_data, e); end
        $display("frame t2b data=%h expected=%h", frm.frame_data, e);
        cont = 1'b0; ready = 1'b1; step(); ready = 1'b0; exp_pkts++;
        checks++; if (pkt_count !== 16'(exp_pkts) || busy !== 1'b0) begin errors++; $display("FAIL t2_end: pkt=%0d busy=%b want %0d/0", pkt_count, busy, exp_pkts); end
    endtask

    task automatic test_drop_sat();
        logic [63:0] w, e;
        int n, len;
        bit ok;
        arm = 1'b1; step(); arm = 1'b0;
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL t_sat_arm_clear: got %0d want 0", drop_count); end
        wait_flush(len, ok);
        w = mk_word(); shift_bits(w, 64); exp_q.push_back(w);
        wait_frame(1'b0, n, ok);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        checks++; if (!ok || frm.frame_data !== e) begin errors++; $display("FAIL t_sat_data: got %h want %h", frm.frame_data, e); end
        $display("frame tsat data=%h expected=%h", frm.frame_data, e);
        bit_strobe = 1'b1;
        repeat (300) step();
        bit_strobe = 1'b0;
        checks++; if (drop_count !== 8'd255 || frm.frame_valid !== 1'b1) begin errors++; $display("FAIL t_sat_drop: drop=%0d valid=%b want 255/1", drop_count, frm.frame_valid); end
        ready = 1'b1; step(); ready = 1'b0; exp_pkts++;
        checks++; if (pkt_count !== 16'(exp_pkts)) begin errors++; $display("FAIL t_sat_pkt: got %0d want %0d", pkt_count, exp_pkts); end
    endtask

    task automatic test_min_bits();
        logic [63:0] w, e;
        int n, len;
        bit ok, early;
        arm = 1'b1; step(); arm = 1'b0;
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL t3_arm_clear: got %0d want 0", drop_count); end
        wait_flush(len, ok);
        shift_bits(64'd0, 40);
        force_rec = 1'b1; early = 1'b0;
        for (int k = 0; k < 5; k++) begin step(); if (frm.frame_valid !== 1'b0) early = 1'b1; end
        force_rec = 1'b0;
        checks++; if (early || busy !== 1'b1) begin errors++; $display("FAIL t3_early_capture: early=%b busy=%b want 0/1", early, busy); end
        w = mk_word(); shift_bits(w, 64); exp_q.push_back(w);
        wait_frame(1'b1, n, ok);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        checks++; if (!ok || frm.frame_data !== e) begin errors++; $display("FAIL t3_data: got %h want %h valid=%b", frm.frame_data, e, ok); end
        $display("frame t3 data=%h expected=%h", frm.frame_data, e);
        ready = 1'b1; step(); ready = 1'b0; exp_pkts++;
        checks++; if (pkt_count !== 16'(exp_pkts) || busy !== 1'b0) begin errors++; $display("FAIL t3_end: pkt=%0d busy=%b want %0d/0", pkt_count, busy, exp_pkts); end
    endtask

    task automatic test_timeout();
        int n;
        arm_to = 1'b1; step(); arm_to = 1'b0;
        n = 0;
        while (busy_to && n < 100) begin n++; step(); end
        checks++; if (n != 18) begin errors++; $display("FAIL t4_busy_cycles: got %0d want 18", n); end
        checks++; if (timeout_to !== 1'b1) begin errors++; $display("FAIL t4_timeout_set: got %b want 1", timeout_to); end
        arm_to = 1'b1; step(); arm_to = 1'b0;
        checks++; if (timeout_to !== 1'b0 || busy_to !== 1'b1) begin errors++; $display("FAIL t4_rearm: timeout=%b busy=%b want 0/1", timeout_to, busy_to); end
        abort = 1'b1; step(); abort = 1'b0;
        checks++; if (busy_to !== 1'b0 || timeout_to !== 1'b0) begin errors++; $display("FAIL t4_abort: busy=%b timeout=%b want 0/0", busy_to, timeout_to); end
    endtask

    task automatic test_abort();
        logic [63:0] w, e;
        int n, len;
        bit ok;
        cont = 1'b0; arm = 1'b1; step(); arm = 1'b0;
        wait_flush(len, ok);
        w = mk_word(); shift_bits(w, 64); exp_q.push_back(w);
        wait_frame(1'b0, n, ok);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        checks++; if (!ok || frm.frame_data !== e) begin errors++; $display("FAIL t5_data: got %h want %h", frm.frame_data, e); end
        $display("frame t5 data=%h expected=%h (aborted)", frm.frame_data, e);
        bit_strobe = 1'b1; repeat (3) step(); bit_strobe = 1'b0;
        arm = 1'b1; step(); arm = 1'b0;
        checks++; if (frm.frame_valid !== 1'b1 || busy !== 1'b1 || drop_count !== 8'd3) begin errors++; $display("FAIL t5_arm_busy: valid=%b busy=%b drop=%0d want 1/1/3", frm.frame_valid, busy, drop_count); end
        abort = 1'b1; step(); abort = 1'b0;
        checks++; if (frm.frame_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL t5_abort: valid=%b busy=%b want 0/0", frm.frame_valid, busy); end
        checks++; if (pkt_count !== 16'(exp_pkts)) begin errors++; $display("FAIL t5_pkt_count: got %0d want %0d", pkt_count, exp_pkts); end
    endtask

    task automatic test_async_rst();
        int len;
        bit ok;
        arm = 1'b1; step(); arm = 1'b0;
        wait_flush(len, ok);
        shift_bits(mk_word(), 20);
        bit_strobe = 1'b1;
        @(posedge clk); #3;
        checks++; if (sb_en !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL t6_pre: sb_en=%b busy=%b want 1/1", sb_en, busy); end
        rst = 1'b1; #1;
        checks++; if (busy !== 1'b0 || sb_en !== 1'b0 || sb_rst !== 1'b0) begin errors++; $display("FAIL t6_state: busy=%b sb_en=%b sb_rst=%b want 0", busy, sb_en, sb_rst); end
        checks++; if (frm.frame_valid !== 1'b0 || frm.frame_data !== '0) begin errors++; $display("FAIL t6_frame: valid=%b data=%h want 0", frm.frame_valid, frm.frame_data); end
        checks++; if (pkt_count !== 16'd0 || drop_count !== 8'd0 || timeout !== 1'b0) begin errors++; $display("FAIL t6_counts: pkt=%0d drop=%0d to=%b want 0", pkt_count, drop_count, timeout); end
        bit_strobe = 1'b0; exp_pkts = 0;
        step(); rst = 1'b0; step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_drop_sat();
        test_min_bits();
        test_timeout();
        test_abort();
        test_async_rst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
